// File: rtl/mac_vert_pkg.sv
// Shared constants, state type and helpers for the vertical bit-column MAC sequencer.
package mac_vert_pkg;
  localparam logic [3:0] NULL_SEL        = 4'd8;
  localparam logic [4:0] NULL_HAM        = 5'd16;
  localparam int         LANES_PER_GROUP = 4;
  localparam int         GROUP_SIZE      = 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} seq_state_t;

  function automatic logic [3:0] popcount8(input logic [7:0] b);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int n = 0; n < 8; n++) cnt = cnt + {3'd0, b[n]};
    return cnt;
  endfunction
endpackage

// File: rtl/col_group_encoder.sv
// Encodes one 8-bit column slice into a skip flag and 4 ascending lane indices.
// Sparse side is selected: ones when popcount <= 4, zeros otherwise; unused lanes get NULL_SEL.
module col_group_encoder
  import mac_vert_pkg::*;
#(
  parameter int SEL_W = 4
) (
  input  logic [GROUP_SIZE-1:0]                  col_bits,
  output logic                                   skip_zero,
  output logic [LANES_PER_GROUP-1:0][SEL_W-1:0]  sel
);

  logic [GROUP_SIZE-1:0] pick;
  logic [2:0]            lane;

  always_comb begin
    skip_zero = (popcount8(col_bits) <= 4'd4);
    pick      = skip_zero ? col_bits : ~col_bits;
    sel       = {LANES_PER_GROUP{SEL_W'(NULL_SEL)}};
    lane      = 3'd0;
    // At most 4 bits can be picked, so lane never overruns
    for (int n = 0; n < GROUP_SIZE; n++) begin
      if (pick[n] && (lane < 3'd4)) begin
        sel[lane[1:0]] = SEL_W'(n);
        lane           = lane + 3'd1;
      end
    end
  end

endmodule

// File: rtl/mac_vert_col_sequencer.sv
// Sequences a stored weight vector column by column (LSB first) into the bit-column MAC controls.
// A new vector may be accepted on the last column; that first column doubles as the old vector's drain.
module mac_vert_col_sequencer
  import mac_vert_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int VEC_LENGTH    = 16,
  parameter int MUX_SEL_WIDTH = $clog2(VEC_LENGTH) + 1
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          w_valid,
  output logic                                          w_ready,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]         w_data,
  output logic                                          en,
  output logic                                          load_accum,
  output logic [VEC_LENGTH/2-1:0][MUX_SEL_WIDTH-2:0]    act_sel,
  output logic [VEC_LENGTH/8-1:0]                       is_skip_zero,
  output logic [2:0]                                    column_idx,
  output logic                                          is_msb,
  output logic [MUX_SEL_WIDTH-1:0]                      hamming_sel,
  output logic                                          hamming_sign,
  output logic [1:0]                                    hamming_shift_sel,
  output logic [2:0]                                    mul_const,
  output logic                                          is_shift_mul,
  output logic                                          result_valid
);

  localparam int         NGROUPS  = VEC_LENGTH / GROUP_SIZE;
  localparam int         SEL_W    = MUX_SEL_WIDTH - 1;
  localparam logic [2:0] LAST_COL = 3'(DATA_WIDTH - 1);

  seq_state_t state_q, state_d;
  logic [2:0] col_q, col_d;
  logic       drain_q, drain_d;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w_q;

  logic       en_q, load_accum_q, result_valid_q, is_msb_q, w_ready_q;
  logic [2:0] column_idx_q;
  logic [NGROUPS-1:0][LANES_PER_GROUP-1:0][SEL_W-1:0] act_sel_q;
  logic [NGROUPS-1:0]                                 skip_q;

  logic                                               hs;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]              enc_src;
  logic [2:0]                                         enc_col;
  logic [NGROUPS-1:0][GROUP_SIZE-1:0]                 col_bits;
  logic [NGROUPS-1:0][LANES_PER_GROUP-1:0][SEL_W-1:0] enc_sel;
  logic [NGROUPS-1:0]                                 enc_skip;

  assign hs = w_valid & w_ready_q;

  // Encode the column that will be presented next cycle, from fresh data on a handshake
  assign enc_src = hs ? w_data : w_q;
  assign enc_col = hs ? 3'd0 : col_q + 3'd1;

  always_comb begin
    col_bits = '0;
    for (int g = 0; g < NGROUPS; g++)
      for (int n = 0; n < GROUP_SIZE; n++)
        col_bits[g][n] = enc_src[g*GROUP_SIZE + n][enc_col];
  end

  for (genvar g = 0; g < NGROUPS; g++) begin : g_enc
    col_group_encoder #(.SEL_W(SEL_W)) u_enc (
      .col_bits  (col_bits[g]),
      .skip_zero (enc_skip[g]),
      .sel       (enc_sel[g])
    );
  end

  always_comb begin
    state_d = state_q;
    col_d   = 3'd0;
    unique case (state_q)
      IDLE:  if (hs) state_d = RUN;
      RUN: begin
        if (col_q != LAST_COL) col_d = col_q + 3'd1;
        else if (!hs)          state_d = DRAIN;
      end
      DRAIN: state_d = hs ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
    drain_d = (state_d == DRAIN) || (state_q == RUN && col_q == LAST_COL && hs);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      col_q          <= 3'd0;
      drain_q        <= 1'b0;
      w_q            <= '0;
      en_q           <= 1'b0;
      load_accum_q   <= 1'b0;
      result_valid_q <= 1'b0;
      is_msb_q       <= 1'b0;
      w_ready_q      <= 1'b1;
      column_idx_q   <= 3'd0;
      act_sel_q      <= {(NGROUPS*LANES_PER_GROUP){SEL_W'(NULL_SEL)}};
      skip_q         <= '1;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      drain_q        <= drain_d;
      if (hs) w_q    <= w_data;
      en_q           <= (state_d != IDLE);
      load_accum_q   <= (state_d == RUN) && (col_d == 3'd1);
      result_valid_q <= drain_q;
      is_msb_q       <= (state_d == RUN) && (col_d == LAST_COL);
      w_ready_q      <= (state_d != RUN) || (col_d == LAST_COL);
      column_idx_q   <= col_d;
      // Outside RUN the MAC must add zero: null lanes, skip-zero mode
      if (state_d == RUN) begin
        act_sel_q <= enc_sel;
        skip_q    <= enc_skip;
      end else begin
        act_sel_q <= {(NGROUPS*LANES_PER_GROUP){SEL_W'(NULL_SEL)}};
        skip_q    <= '1;
      end
    end
  end

  assign w_ready           = w_ready_q;
  assign en                = en_q;
  assign load_accum        = load_accum_q;
  assign result_valid      = result_valid_q;
  assign is_msb            = is_msb_q;
  assign column_idx        = column_idx_q;
  assign act_sel           = act_sel_q;
  assign is_skip_zero      = skip_q;
  assign hamming_sel       = MUX_SEL_WIDTH'(NULL_HAM);
  assign hamming_sign      = 1'b0;
  assign hamming_shift_sel = 2'd0;
  assign mul_const         = 3'd0;
  assign is_shift_mul      = 1'b0;

endmodule

// File: tb/tb_mac_vert_col_sequencer.sv
// Bench for mac_vert_col_sequencer: timeline reference model built from per-vector acceptance times.
module tb_mac_vert_col_sequencer;
  localparam int DW = 8;
  localparam int VL = 16;
  localparam int MW = 5;

  typedef logic [VL-1:0][DW-1:0] wvec_t;
  typedef logic [7:0][3:0]       sel_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic w_valid = 1'b0;
  logic w_ready;
  wvec_t w_data = '0;
  logic en, load_accum, is_msb, result_valid;
  logic [VL/2-1:0][MW-2:0] act_sel;
  logic [VL/8-1:0] is_skip_zero;
  logic [2:0] column_idx;
  logic [MW-1:0] hamming_sel;
  logic hamming_sign, is_shift_mul;
  logic [1:0] hamming_shift_sel;
  logic [2:0] mul_const;

  int n_tests = 0;
  int n_fail  = 0;

  wvec_t pv[$];
  int    pgap[$];

  always #5 clk = ~clk;

  mac_vert_col_sequencer dut (
    .clk(clk), .reset(reset), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .en(en), .load_accum(load_accum), .act_sel(act_sel), .is_skip_zero(is_skip_zero),
    .column_idx(column_idx), .is_msb(is_msb), .hamming_sel(hamming_sel),
    .hamming_sign(hamming_sign), .hamming_shift_sel(hamming_shift_sel),
    .mul_const(mul_const), .is_shift_mul(is_shift_mul), .result_valid(result_valid)
  );

  function automatic sel_t null_sel();
    sel_t s;
    for (int j = 0; j < 8; j++) s[j] = 4'd8;
    return s;
  endfunction

  // Reference column encoding: list the sparse bit positions, pad with 8
  function automatic void encode(input wvec_t v, input int k, output logic [1:0] skip, output sel_t sel);
    int ones[$];
    int zeros[$];
    int lst[$];
    for (int g = 0; g < 2; g++) begin
      ones.delete(); zeros.delete(); lst.delete();
      for (int n = 0; n < 8; n++) begin
        if (v[8*g+n][k]) ones.push_back(n);
        else             zeros.push_back(n);
      end
      skip[g] = (ones.size() <= 4);
      if (skip[g]) lst = ones;
      else         lst = zeros;
      for (int j = 0; j < 4; j++)
        sel[4*g+j] = (j < lst.size()) ? 4'(lst[j]) : 4'd8;
    end
  endfunction

  function automatic wvec_t gen_vec(input int mode);
    wvec_t v;
    for (int i = 0; i < VL; i++) begin
      case (mode)
        1:       v[i] = 8'($urandom & $urandom & $urandom);
        2:       v[i] = 8'($urandom | $urandom | $urandom);
        default: v[i] = 8'($urandom);
      endcase
    end
    return v;
  endfunction

  // Drive the queued vectors (pv, with idle gaps pgap) and compare every cycle against the timeline
  task automatic run_plan(input string name);
    int n, len, cur;
    int off[];
    int acc[];
    bit   e_en[], e_ld[], e_rv[], e_rdy[], e_msb[];
    int   e_col[];
    sel_t e_sel[];
    logic [1:0] e_skip[];
    logic [1:0] sk;
    sel_t sl;
    n = pv.size();
    off = new[n];
    acc = new[n];
    for (int i = 0; i < n; i++) begin
      off[i] = (i == 0) ? pgap[0] : acc[i-1] + 1 + pgap[i];
      acc[i] = (i == 0) ? off[i] : ((off[i] > acc[i-1] + 8) ? off[i] : acc[i-1] + 8);
    end
    len = acc[n-1] + 12;
    e_en = new[len]; e_ld = new[len]; e_rv = new[len]; e_rdy = new[len]; e_msb = new[len];
    e_col = new[len]; e_sel = new[len]; e_skip = new[len];
    for (int c = 0; c < len; c++) begin
      e_rdy[c] = 1'b1; e_sel[c] = null_sel(); e_skip[c] = 2'b11;
    end
    for (int i = 0; i < n; i++) begin
      e_en[acc[i]+9]  = 1'b1;
      e_rv[acc[i]+10] = 1'b1;
      for (int k = 0; k < 8; k++) begin
        int c;
        c = acc[i] + 1 + k;
        encode(pv[i], k, sk, sl);
        e_en[c] = 1'b1; e_col[c] = k; e_msb[c] = (k == 7); e_ld[c] = (k == 1);
        e_rdy[c] = (k == 7); e_sel[c] = sl; e_skip[c] = sk;
      end
    end
    for (int c = 0; c < len; c++) begin
      cur = -1;
      for (int i = 0; i < n; i++) if (c >= off[i] && c <= acc[i]) cur = i;
      if (cur >= 0) begin w_valid = 1'b1; w_data = pv[cur]; end
      else          begin w_valid = 1'b0; w_data = gen_vec(0); end
      @(negedge clk);
      n_tests++; if (en !== e_en[c]) begin n_fail++; $display("FAIL %s c%0d en: got %b exp %b", name, c, en, e_en[c]); end
      n_tests++; if (load_accum !== e_ld[c]) begin n_fail++; $display("FAIL %s c%0d load_accum: got %b exp %b", name, c, load_accum, e_ld[c]); end
      n_tests++; if (result_valid !== e_rv[c]) begin n_fail++; $display("FAIL %s c%0d result_valid: got %b exp %b", name, c, result_valid, e_rv[c]); end
      n_tests++; if (w_ready !== e_rdy[c]) begin n_fail++; $display("FAIL %s c%0d w_ready: got %b exp %b", name, c, w_ready, e_rdy[c]); end
      n_tests++; if (column_idx !== 3'(e_col[c])) begin n_fail++; $display("FAIL %s c%0d column_idx: got %0d exp %0d", name, c, column_idx, e_col[c]); end
      n_tests++; if (is_msb !== e_msb[c]) begin n_fail++; $display("FAIL %s c%0d is_msb: got %b exp %b", name, c, is_msb, e_msb[c]); end
      n_tests++; if (act_sel !== e_sel[c]) begin n_fail++; $display("FAIL %s c%0d act_sel: got %h exp %h", name, c, act_sel, e_sel[c]); end
      n_tests++; if (is_skip_zero !== e_skip[c]) begin n_fail++; $display("FAIL %s c%0d is_skip_zero: got %b exp %b", name, c, is_skip_zero, e_skip[c]); end
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (en !== 1'b0 || load_accum !== 1'b0 || result_valid !== 1'b0 || is_msb !== 1'b0) begin
      n_fail++; $display("FAIL reset ctl: got en%b ld%b rv%b msb%b exp all 0", en, load_accum, result_valid, is_msb); end
    n_tests++; if (w_ready !== 1'b1 || column_idx !== 3'd0) begin
      n_fail++; $display("FAIL reset rdy/col: got %b/%0d exp 1/0", w_ready, column_idx); end
    n_tests++; if (act_sel !== null_sel() || is_skip_zero !== 2'b11) begin
      n_fail++; $display("FAIL reset sel: got %h/%b exp 88888888/11", act_sel, is_skip_zero); end
    n_tests++; if (hamming_sel !== 5'd16 || hamming_sign !== 1'b0 || hamming_shift_sel !== 2'd0 || mul_const !== 3'd0 || is_shift_mul !== 1'b0) begin
      n_fail++; $display("FAIL reset const: got ham%0d sgn%b sh%0d mc%0d sm%b exp 16 0 0 0 0",
                         hamming_sel, hamming_sign, hamming_shift_sel, mul_const, is_shift_mul); end
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_vector();
    pv.delete(); pgap.delete();
    pv.push_back('0); pgap.push_back(0);
    run_plan("zero");
  endtask

  task automatic test_pattern();
    wvec_t v;
    for (int n = 0; n < VL; n++) v[n] = (n < 8) ? 8'(n) : 8'h7F;
    pv.delete(); pgap.delete();
    pv.push_back(v); pgap.push_back(1);
    run_plan("pattern");
  endtask

  task automatic test_all_ones();
    pv.delete(); pgap.delete();
    pv.push_back('1); pgap.push_back(0);
    run_plan("all_ff");
  endtask

  task automatic test_back_to_back();
    pv.delete(); pgap.delete();
    pv.push_back(gen_vec(0)); pgap.push_back(0);
    pv.push_back(gen_vec(0)); pgap.push_back(0);
    run_plan("back_to_back");
  endtask

  task automatic test_skip_pattern();
    wvec_t v;
    logic [7:0] pat;
    pat = 8'hED;
    v = gen_vec(0);
    for (int n = 0; n < 8; n++) v[n][0] = pat[n];
    pv.delete(); pgap.delete();
    pv.push_back(v); pgap.push_back(0);
    run_plan("skip_pattern");
  endtask

  task automatic test_random();
    pv.delete(); pgap.delete();
    for (int i = 0; i < 8; i++) begin
      pv.push_back(gen_vec(int'($urandom_range(0, 2))));
      pgap.push_back(int'($urandom_range(0, 12)));
    end
    run_plan("random");
  endtask

  task automatic test_reset_midrun();
    w_valid = 1'b1; w_data = gen_vec(0);
    @(posedge clk); #1 w_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    n_tests++; if (column_idx !== 3'd4 || en !== 1'b1) begin
      n_fail++; $display("FAIL midrun pre: got col%0d en%b exp col4 en1", column_idx, en); end
    reset = 1'b1;
    #1;
    n_tests++; if (en !== 1'b0 || w_ready !== 1'b1 || column_idx !== 3'd0) begin
      n_fail++; $display("FAIL midrun rst: got en%b rdy%b col%0d exp 0 1 0", en, w_ready, column_idx); end
    n_tests++; if (act_sel !== null_sel() || is_skip_zero !== 2'b11) begin
      n_fail++; $display("FAIL midrun rst sel: got %h/%b exp 88888888/11", act_sel, is_skip_zero); end
    @(posedge clk); #1 reset = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      n_tests++; if (result_valid !== 1'b0 || en !== 1'b0) begin
        n_fail++; $display("FAIL midrun after c%0d: got rv%b en%b exp 0 0", c, result_valid, en); end
      @(posedge clk); #1;
    end
    pv.delete(); pgap.delete();
    pv.push_back(gen_vec(0)); pgap.push_back(0);
    run_plan("after_reset");
  endtask

  initial begin
    test_reset();
    test_zero_vector();
    test_pattern();
    test_all_ones();
    test_back_to_back();
    test_skip_pattern();
    test_random();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
